switch_mcu_gpr_wb_ctrl: RTL and testbench

SWITCH_MCU_GPR_WB_CTRL -- requirements
Module: switch_mcu_gpr_wb_ctrl

---
 rtl/switch_mcu_pkg.sv | 25 ++
 rtl/switch_mcu_gpr_wb_ctrl_if.sv | 34 +++
 rtl/switch_mcu_rr_arbiter.sv | 51 +++++
 rtl/switch_mcu_gpr_wb_ctrl.sv | 89 ++++++++
 tb/tb_switch_mcu_gpr_wb_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/switch_mcu_pkg.sv
// Shared widths and writeback requester identities for the GPR writeback controller.
package switch_mcu_pkg;

    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned GPR_DATA_W = 32;
    localparam int unsigned NUM_WB_REQ = 3;
    localparam int unsigned GPR_NUM    = 1 << GPR_ADDR_W;

    // Requester indices; also used as the round-robin pointer state.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_CSR = 2'd2
    } wb_req_e;

    // Requester that follows r in round-robin order.
    function automatic wb_req_e wb_next(input wb_req_e r);
        case (r)
            WB_ALU:  return WB_LSU;
            WB_LSU:  return WB_CSR;
            default: return WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/switch_mcu_gpr_wb_ctrl_if.sv
// Writeback request bus, GPR write port and scoreboard reserve/check signals.
interface switch_mcu_gpr_wb_ctrl_if;
    import switch_mcu_pkg::*;

    logic [NUM_WB_REQ-1:0]            in_req_valid;
    logic [NUM_WB_REQ*GPR_ADDR_W-1:0] in_req_addr;
    logic [NUM_WB_REQ*GPR_DATA_W-1:0] in_req_data;
    logic [NUM_WB_REQ-1:0]            out_req_ready;
    logic                             out_gpr_wen;
    logic [GPR_ADDR_W-1:0]            out_gpr_waddr;
    logic [GPR_DATA_W-1:0]            out_gpr_wdata;
    logic                             in_rsv_en;
    logic [GPR_ADDR_W-1:0]            in_rsv_addr;
    logic [GPR_ADDR_W-1:0]            in_chk_addr_1;
    logic [GPR_ADDR_W-1:0]            in_chk_addr_2;
    logic                             out_chk_busy_1;
    logic                             out_chk_busy_2;
    logic [GPR_NUM-1:0]               out_busy_vec;

    modport master (
        output in_req_valid, in_req_addr, in_req_data,
        output in_rsv_en, in_rsv_addr, in_chk_addr_1, in_chk_addr_2,
        input  out_req_ready, out_gpr_wen, out_gpr_waddr, out_gpr_wdata,
        input  out_chk_busy_1, out_chk_busy_2, out_busy_vec
    );

    modport slave (
        input  in_req_valid, in_req_addr, in_req_data,
        input  in_rsv_en, in_rsv_addr, in_chk_addr_1, in_chk_addr_2,
        output out_req_ready, out_gpr_wen, out_gpr_waddr, out_gpr_wdata,
        output out_chk_busy_1, out_chk_busy_2, out_busy_vec
    );

endinterface

// File: rtl/switch_mcu_rr_arbiter.sv
// Three-way round-robin arbiter: grant is combinational, pointer advances past the winner.
module switch_mcu_rr_arbiter
    import switch_mcu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_WB_REQ-1:0] i_valid,
    output logic [NUM_WB_REQ-1:0] o_grant
);

    wb_req_e r_ptr;
    wb_req_e w_ptr_nxt;

    // Pointer register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= WB_ALU;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Pick the first valid requester starting at the pointer; no grant during reset.
    always_comb begin
        o_grant   = '0;
        w_ptr_nxt = r_ptr;
        if (!i_rst) begin
            case (r_ptr)
                WB_LSU: begin
                    if      (i_valid[1]) o_grant = 3'b010;
                    else if (i_valid[2]) o_grant = 3'b100;
                    else if (i_valid[0]) o_grant = 3'b001;
                end
                WB_CSR: begin
                    if      (i_valid[2]) o_grant = 3'b100;
                    else if (i_valid[0]) o_grant = 3'b001;
                    else if (i_valid[1]) o_grant = 3'b010;
                end
                default: begin
                    if      (i_valid[0]) o_grant = 3'b001;
                    else if (i_valid[1]) o_grant = 3'b010;
                    else if (i_valid[2]) o_grant = 3'b100;
                end
            endcase
            if      (o_grant[0]) w_ptr_nxt = wb_next(WB_ALU);
            else if (o_grant[1]) w_ptr_nxt = wb_next(WB_LSU);
            else if (o_grant[2]) w_ptr_nxt = wb_next(WB_CSR);
        end
    end

endmodule

// File: rtl/switch_mcu_gpr_wb_ctrl.sv
// GPR writeback controller: arbitrates writeback requesters onto the register file
// write port (one cycle registered) and tracks pending destination registers.
module switch_mcu_gpr_wb_ctrl #(
    parameter int unsigned GPR_ADDR_W = switch_mcu_pkg::GPR_ADDR_W,
    parameter int unsigned GPR_DATA_W = switch_mcu_pkg::GPR_DATA_W,
    parameter int unsigned NUM_WB_REQ = switch_mcu_pkg::NUM_WB_REQ
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    switch_mcu_gpr_wb_ctrl_if.slave  bus
);

    localparam int unsigned GPR_NUM = 1 << GPR_ADDR_W;

    logic [NUM_WB_REQ-1:0] w_grant;
    logic                  w_xfer;
    logic [GPR_ADDR_W-1:0] w_sel_addr;
    logic [GPR_DATA_W-1:0] w_sel_data;
    logic [GPR_NUM-1:0]    w_busy_nxt;

    logic                  r_wen;
    logic [GPR_ADDR_W-1:0] r_waddr;
    logic [GPR_DATA_W-1:0] r_wdata;
    logic [GPR_NUM-1:0]    r_busy;

    switch_mcu_rr_arbiter u_arb (
        .i_clk   (in_clk),
        .i_rst   (in_rst),
        .i_valid (bus.in_req_valid),
        .o_grant (w_grant)
    );

    assign w_xfer            = |w_grant;
    assign bus.out_req_ready = w_grant;

    // Route the granted requester's address/data onto the write path.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_WB_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = bus.in_req_addr[i*GPR_ADDR_W +: GPR_ADDR_W];
                w_sel_data = bus.in_req_data[i*GPR_DATA_W +: GPR_DATA_W];
            end
        end
    end

    // Register the accepted write; x0 writes complete the handshake but never reach the file.
    always_ff @(posedge in_clk) begin
        if (in_rst || !w_xfer || (w_sel_addr == '0)) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen   <= 1'b1;
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
        end
    end

    // Scoreboard next state: writeback clears, reservation applied after so it wins; x0 pinned low.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_xfer) begin
            w_busy_nxt[w_sel_addr] = 1'b0;
        end
        if (bus.in_rsv_en) begin
            w_busy_nxt[bus.in_rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.out_gpr_wen    = r_wen;
    assign bus.out_gpr_waddr  = r_waddr;
    assign bus.out_gpr_wdata  = r_wdata;
    assign bus.out_busy_vec   = r_busy;
    assign bus.out_chk_busy_1 = r_busy[bus.in_chk_addr_1];
    assign bus.out_chk_busy_2 = r_busy[bus.in_chk_addr_2];

endmodule

// File: tb/tb_switch_mcu_gpr_wb_ctrl.sv
// Scoreboard bench for the GPR writeback controller: a driver pushes per-cycle
// expectations from a behavioural model, a monitor pops and compares on the falling edge.
module tb_switch_mcu_gpr_wb_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_mcu_gpr_wb_ctrl_if bus();

    switch_mcu_gpr_wb_ctrl #(
        .GPR_ADDR_W (5),
        .GPR_DATA_W (32),
        .NUM_WB_REQ (3)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0]  ready;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic        c1;
        logic        c2;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Pending requests per requester; held until the model grants them.
    bit          p_valid[3];
    logic [4:0]  p_addr[3];
    logic [31:0] p_data[3];

    // Reference model state.
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_wen;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_data[i]  = d;
    endtask

    // Drive one cycle, record what should be seen during it, then advance the model.
    task automatic drive_cycle(input bit rst_i, input bit rsv_en, input logic [4:0] rsv_addr,
                               input logic [4:0] c1, input logic [4:0] c2);
        exp_t e;
        int   g;
        g   = -1;
        rst = rst_i;
        for (int i = 0; i < 3; i++) begin
            bus.in_req_valid[i]        = p_valid[i];
            bus.in_req_addr[i*5 +: 5]  = p_addr[i];
            bus.in_req_data[i*32 +: 32] = p_data[i];
        end
        bus.in_rsv_en     = rsv_en;
        bus.in_rsv_addr   = rsv_addr;
        bus.in_chk_addr_1 = c1;
        bus.in_chk_addr_2 = c2;

        if (!rst_i) begin
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (m_ptr + k) % 3;
                if (g < 0 && p_valid[idx]) g = idx;
            end
        end
        e.ready = (g < 0) ? 3'b000 : 3'(1 << g);
        e.wen   = m_wen;
        e.waddr = m_waddr;
        e.wdata = m_wdata;
        e.busy  = m_busy;
        e.c1    = m_busy[c1];
        e.c2    = m_busy[c2];
        sb_q.push_back(e);

        if (rst_i) begin
            m_ptr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
            if (g >= 0) begin
                m_ptr = (g + 1) % 3;
                if (p_addr[g] != 5'd0) begin
                    m_wen = 1'b1; m_waddr = p_addr[g]; m_wdata = p_data[g];
                end
                m_busy[p_addr[g]] = 1'b0;
                p_valid[g] = 1'b0;
            end
            if (rsv_en) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] c1);
        drive_cycle(1'b0, 1'b0, 5'd0, c1, 5'd0);
    endtask

    // Monitor: every falling edge with an outstanding expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_field("req_ready",  {29'd0, bus.out_req_ready}, {29'd0, e.ready});
                check_field("gpr_wen",    {31'd0, bus.out_gpr_wen},   {31'd0, e.wen});
                check_field("gpr_waddr",  {27'd0, bus.out_gpr_waddr}, {27'd0, e.waddr});
                check_field("gpr_wdata",  bus.out_gpr_wdata,          e.wdata);
                check_field("busy_vec",   bus.out_busy_vec,           e.busy);
                check_field("chk_busy_1", {31'd0, bus.out_chk_busy_1}, {31'd0, e.c1});
                check_field("chk_busy_2", {31'd0, bus.out_chk_busy_2}, {31'd0, e.c2});
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            p_valid[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        rst               = 1'b1;
        bus.in_req_valid  = '0;
        bus.in_req_addr   = '0;
        bus.in_req_data   = '0;
        bus.in_rsv_en     = 1'b0;
        bus.in_rsv_addr   = '0;
        bus.in_chk_addr_1 = '0;
        bus.in_chk_addr_2 = '0;
        m_ptr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle.
        idle(5'd0);
        idle(5'd1);

        // All three requesters continuously valid: grants 0,1,2,0 and back-to-back writes.
        set_req(0, 5'd1, 32'hAAAA_0001);
        set_req(1, 5'd2, 32'hBBBB_0002);
        set_req(2, 5'd3, 32'hCCCC_0003);
        idle(5'd0);
        set_req(0, 5'd1, 32'hAAAA_0001);
        idle(5'd0);
        idle(5'd0);
        idle(5'd0);
        idle(5'd0);

        // Reserve x5, check it busy, requester 1 writes it, cleared with the write.
        drive_cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        set_req(1, 5'd5, 32'h5555_1234);
        idle(5'd5);
        idle(5'd5);

        // Reserve and writeback of x7 in the same cycle: reservation wins.
        set_req(0, 5'd7, 32'h7777_0007);
        drive_cycle(1'b0, 1'b1, 5'd7, 5'd7, 5'd0);
        idle(5'd7);
        set_req(1, 5'd7, 32'h7777_1111);
        idle(5'd7);
        idle(5'd7);

        // Write to x0 handshakes without a register write; reserving x0 is ignored.
        set_req(2, 5'd0, 32'hDEAD_BEEF);
        drive_cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0);

        // Reset mid-stream with requests pending.
        set_req(0, 5'd9, 32'h9999_0009);
        drive_cycle(1'b0, 1'b1, 5'd3, 5'd3, 5'd9);
        set_req(0, 5'd10, 32'h1010_1010);
        set_req(1, 5'd11, 32'h1111_1111);
        set_req(2, 5'd12, 32'h1212_1212);
        drive_cycle(1'b1, 1'b0, 5'd0, 5'd3, 5'd0);
        idle(5'd3);
        idle(5'd3);
        idle(5'd3);
        idle(5'd3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!p_valid[i] && $urandom_range(0, 99) < 60) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 5'($urandom_range(0, 31)), $urandom);
                    else                           set_req(i, 5'($urandom_range(0, 7)), $urandom);
                end
            end
            drive_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 3; i++) p_valid[i] = 1'b0;
        idle(5'd0);

        @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
